// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous display update.
// A load is held in a pending register and promoted to the display only at the slot-3 tick.
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    slot;
    logic [3:0]    pend [4];
    logic [3:0]    disp [4];
    logic          tick;
    logic          boundary;
    logic [3:0]    cur;
    logic          blank;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    assign tick     = (cnt == LAST);
    assign boundary = tick && (slot == 2'd3);
    assign dp       = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            slot <= 2'd0;
            busy <= 1'b0;
            an   <= 4'b1111;
            seg  <= 7'h7F;
            for (int i = 0; i < 4; i++) begin
                pend[i] <= 4'd0;
                disp[i] <= 4'd0;
            end
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) slot <= slot + 2'd1;
            // A load landing exactly on the boundary bypasses pending entirely.
            if (load && boundary) begin
                disp[0] <= in0;
                disp[1] <= in1;
                disp[2] <= in2;
                disp[3] <= in3;
                busy    <= 1'b0;
            end else begin
                if (boundary && busy) begin
                    for (int i = 0; i < 4; i++) disp[i] <= pend[i];
                    busy <= 1'b0;
                end
                if (load) begin
                    pend[0] <= in0;
                    pend[1] <= in1;
                    pend[2] <= in2;
                    pend[3] <= in3;
                    busy    <= 1'b1;
                end
            end
            an  <= an_next;
            seg <= seg_next;
        end
    end

    always_comb begin
        cur     = disp[slot];
        an_next = ~(4'b1000 >> slot);
        blank   = 1'b0;
        // Blank a zero only while every digit to its left is also zero.
        if (blank_lz) begin
            case (slot)
                2'd0:    blank = (disp[0] == 4'd0);
                2'd1:    blank = (disp[0] == 4'd0) && (disp[1] == 4'd0);
                2'd2:    blank = (disp[0] == 4'd0) && (disp[1] == 4'd0) && (disp[2] == 4'd0);
                default: blank = 1'b0;
            endcase
        end
        case (cur)
            4'd0:    seg_next = 7'h40;
            4'd1:    seg_next = 7'h79;
            4'd2:    seg_next = 7'h24;
            4'd3:    seg_next = 7'h30;
            4'd4:    seg_next = 7'h19;
            4'd5:    seg_next = 7'h12;
            4'd6:    seg_next = 7'h02;
            4'd7:    seg_next = 7'h78;
            4'd8:    seg_next = 7'h00;
            4'd9:    seg_next = 7'h10;
            default: seg_next = 7'h3F;
        endcase
        if (blank) seg_next = 7'h7F;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per digit slot (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port load  input  1  one-cycle strobe that captures in0..in3.
REQ-005 SHALL have port in0  input  4  thousands BCD digit (leftmost).
REQ-006 SHALL have port in1  input  4  hundreds BCD digit.
REQ-007 SHALL have port in2  input  4  tens BCD digit.
REQ-008 SHALL have port in3  input  4  units BCD digit (rightmost).
REQ-009 SHALL have port blank_lz  input  1  leading-zero blanking enable, sampled each cycle.
REQ-010 SHALL have port an  output  4  digit enables, active-low; an[3] is leftmost.
REQ-011 SHALL have port seg  output  7  segments, active-low; seg[0]=a ... seg[6]=g.
REQ-012 SHALL have port dp  output  1  decimal point, active-low.
REQ-013 SHALL have port busy  output  1  high while a loaded value awaits its frame boundary.

Function
REQ-014 SHALL run a prescaler counting 0..REFRESH_DIV-1, wrapping to 0; tick is asserted when the count equals REFRESH_DIV-1.
REQ-015 SHALL keep a 2-bit slot index that increments on tick and wraps 3->0.
REQ-016 SHALL drive slot k (k=0..3) as an[3-k] low and all other an bits high; slot k displays display digit k (0=in0 ... 3=in3).
REQ-017 SHALL hold a pending register and a display register, each 4x4 bits.
REQ-018 SHALL, on load, copy in0..in3 into pending and set busy; a load while busy=1 overwrites pending.
REQ-019 SHALL define the frame boundary as a tick with slot index 3; at the boundary with busy=1, it copies pending to display and clears busy.
REQ-020 SHALL, on load coinciding with a frame boundary, copy in0..in3 directly to display and leave busy=0.
REQ-021 SHALL never change display contents except at a frame boundary (no tearing within a frame).
REQ-022 SHALL encode digits as seg hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-023 SHALL show a dash (seg=3F) for any digit value 10..15.
REQ-024 SHALL, when blank_lz=1, blank (seg=7F) every zero digit in slots 0..2 that has only zeros to its left; slot 3 is never blanked.
REQ-025 SHALL register an and seg, so outputs reflect the slot index and display contents of the previous cycle (1-cycle latency).
REQ-026 SHALL hold dp at 1 (off) at all times.

Reset
REQ-027 SHALL, with reset high at a clock edge, clear the prescaler, slot index, pending, display, and busy; it SHALL set an=1111 and seg=7F.
REQ-028 SHALL give reset priority over load and tick; a load in the same cycle as reset is discarded.
REQ-029 SHALL, on the first edge after reset deasserts, drive an=0111 with seg=40 (display=0000), or seg=7F if blank_lz=1.

Verification (REFRESH_DIV=4, frame = 16 cycles)
REQ-030 Reset, then load 9,3,2,5 mid-frame -> busy=1 until the next slot-3 tick; the next full frame shows an 0111/1011/1101/1110 with seg 10/30/24/12, 4 cycles each.
REQ-031 blank_lz=1, load 0,0,4,2 -> seg 7F/7F/19/24; the same load with all digits 0 -> 7F/7F/7F/40; with blank_lz=0 -> 40/40/19/24.
REQ-032 Load in1=12, others 1 -> slot 1 shows 3F; slots 0, 2, 3 show 79.
REQ-033 Load A then B before the boundary -> only B is displayed; load coincident with the slot-3 tick -> displayed next frame with busy staying 0.
REQ-034 Assert reset during slot 2 while busy=1 -> next cycle an=1111, seg=7F, busy=0; scanning restarts at slot 0 showing 0.
REQ-035 Over 1000 frames, a checker SHALL confirm exactly one an bit is low after reset, each slot lasts REFRESH_DIV cycles, and dp=1.
